// File: rtl/fp_dp_pkg.sv
// Shared types and constants for the sequential floating-point dot-product engine.
package fp_dp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } dp_state_e;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  localparam logic [7:0] STICKY_MASK = 8'b0011_1100;

  localparam logic [2:0] RM_RNE  = 3'd0;
  localparam logic [2:0] RM_RTZ  = 3'd1;
  localparam logic [2:0] RM_UP   = 3'd2;
  localparam logic [2:0] RM_DOWN = 3'd3;
  localparam logic [2:0] RM_RNA  = 3'd4;
  localparam logic [2:0] RM_AWAY = 3'd5;

endpackage

// File: rtl/fp_dp_mac_step.sv
// Combinational fused multiply-add step: sum = a*b + acc with one rounding,
// denormal inputs read as zero and tiny results flushed to zero.
module fp_dp_mac_step
  import fp_dp_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [sig_width+exp_width:0] acc,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] sum,
  output logic [7:0]                   status
);
  localparam int MW   = sig_width + 1;
  localparam int PW   = 2 * MW;
  localparam int WW   = PW + MW + 4;
  localparam int XW   = exp_width + $clog2(WW) + 3;
  localparam int BIAS = (1 << (exp_width - 1)) - 1;
  localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
  localparam logic signed [XW-1:0] BIAS2_X = XW'(2 * BIAS - 1);
  localparam logic signed [XW-1:0] EMAX_X  = XW'((1 << exp_width) - 1);
  localparam logic signed [XW-1:0] TOP_X   = XW'(WW - 2);
  localparam logic signed [XW-1:0] MSB_X   = XW'(WW - 1);
  localparam logic signed [XW-1:0] WW_X    = XW'(WW);
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X  = XW'(0);
  localparam logic [exp_width-1:0] EXP_ONES = {exp_width{1'b1}};
  localparam logic [exp_width-1:0] EXP_ZERO = {exp_width{1'b0}};
  localparam logic [sig_width+exp_width:0] NAN_OUT = (ieee_compliance != 0) ?
      {1'b0, EXP_ONES, 1'b1, {(sig_width-1){1'b0}}} : {1'b0, EXP_ONES, {sig_width{1'b0}}};

  // Right shift that folds every bit shifted out into the LSB.
  function automatic logic [WW-1:0] shr_jam(input logic [WW-1:0] v, input logic signed [XW-1:0] d);
    logic [WW-1:0] r;
    if (d >= WW_X) begin
      r = {{(WW-1){1'b0}}, |v};
    end else begin
      r = (v >> d) | {{(WW-1){1'b0}}, |(v & ~({WW{1'b1}} << d))};
    end
    return r;
  endfunction

  logic                   sa, sb, sc, sp;
  logic [exp_width-1:0]   ea, eb, ec;
  logic                   a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, p_zero, p_inf, invalid;
  logic [MW-1:0]          ma, mb, mc, mant;
  logic [PW-1:0]          mp;
  logic signed [XW-1:0]   ea_x, eb_x, ec_x, top_p, top_c, top_t, lead, e_pre, e_fin;
  logic [WW-1:0]          xp, yc, s_sum, n_sum;
  logic                   s_sign, g_bit, st_bit, inc, ovf_to_max;
  logic [MW:0]            m_rnd;
  logic [sig_width-1:0]   frac;

  assign sa = a[sig_width+exp_width];
  assign sb = b[sig_width+exp_width];
  assign sc = acc[sig_width+exp_width];
  assign sp = sa ^ sb;
  assign ea = a[sig_width +: exp_width];
  assign eb = b[sig_width +: exp_width];
  assign ec = acc[sig_width +: exp_width];
  assign a_zero = (ea == EXP_ZERO);
  assign b_zero = (eb == EXP_ZERO);
  assign c_zero = (ec == EXP_ZERO);
  assign a_inf  = (ea == EXP_ONES);
  assign b_inf  = (eb == EXP_ONES);
  assign c_inf  = (ec == EXP_ONES);
  assign p_zero = a_zero | b_zero;
  assign p_inf  = (a_inf | b_inf) & ~p_zero;
  assign invalid = (a_inf & b_zero) | (a_zero & b_inf) | (p_inf & c_inf & (sp ^ sc));
  assign ma = {1'b1, a[sig_width-1:0]};
  assign mb = {1'b1, b[sig_width-1:0]};
  assign mc = {1'b1, acc[sig_width-1:0]};
  assign mp = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
  assign ea_x = {{(XW-exp_width){1'b0}}, ea};
  assign eb_x = {{(XW-exp_width){1'b0}}, eb};
  assign ec_x = {{(XW-exp_width){1'b0}}, ec};
  // Exponent of the MSB slot of each operand's integer significand.
  assign top_p = ea_x + eb_x - BIAS2_X;
  assign top_c = ec_x - BIAS_X;

  // Align, add, normalise and round the finite, non-zero-product case.
  always_comb begin
    top_t = (c_zero || (top_p >= top_c)) ? top_p : top_c;
    xp = shr_jam({1'b0, mp, {(WW-PW-1){1'b0}}}, top_t - top_p);
    if (c_zero) begin
      yc = {WW{1'b0}};
    end else begin
      yc = shr_jam({1'b0, mc, {(WW-MW-1){1'b0}}}, top_t - top_c);
    end
    if (sp == sc) begin
      s_sum = xp + yc;
      s_sign = sp;
    end else if (xp >= yc) begin
      s_sum = xp - yc;
      s_sign = sp;
    end else begin
      s_sum = yc - xp;
      s_sign = sc;
    end
    lead = ZERO_X;
    for (int k = 0; k < WW; k++) begin
      lead = s_sum[k] ? XW'(k) : lead;
    end
    n_sum  = s_sum << (MSB_X - lead);
    mant   = n_sum[WW-1 -: MW];
    g_bit  = n_sum[WW-1-MW];
    st_bit = |n_sum[WW-2-MW:0];
    e_pre  = top_t - TOP_X + lead + BIAS_X;
    case (rnd)
      RM_RNE:  inc = g_bit & (st_bit | mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_UP:   inc = ~s_sign & (g_bit | st_bit);
      RM_DOWN: inc = s_sign & (g_bit | st_bit);
      RM_RNA:  inc = g_bit;
      RM_AWAY: inc = g_bit | st_bit;
      default: inc = g_bit & (st_bit | mant[0]);
    endcase
    m_rnd = {1'b0, mant} + {{MW{1'b0}}, inc};
    if (m_rnd[MW]) begin
      e_fin = e_pre + ONE_X;
      frac  = m_rnd[MW-1:1];
    end else begin
      e_fin = e_pre;
      frac  = m_rnd[MW-2:0];
    end
    ovf_to_max = (rnd == RM_RTZ) | ((rnd == RM_UP) & s_sign) | ((rnd == RM_DOWN) & ~s_sign);
  end

  // Special-value priority and final result/status selection.
  always_comb begin
    sum    = {(sig_width+exp_width+1){1'b0}};
    status = 8'h00;
    if (invalid) begin
      sum = NAN_OUT;
      status[ST_INVALID] = 1'b1;
    end else if (p_inf || c_inf) begin
      sum = {(p_inf ? sp : sc), EXP_ONES, {sig_width{1'b0}}};
      status[ST_INF] = 1'b1;
    end else if (p_zero) begin
      if (c_zero) begin
        sum = {(sp & sc) | ((sp ^ sc) & (rnd == RM_DOWN)), {(sig_width+exp_width){1'b0}}};
        status[ST_ZERO] = 1'b1;
      end else begin
        sum = acc;
      end
    end else if (s_sum == {WW{1'b0}}) begin
      sum = {(rnd == RM_DOWN), {(sig_width+exp_width){1'b0}}};
      status[ST_ZERO] = 1'b1;
    end else if (e_fin >= EMAX_X) begin
      status[ST_HUGE] = 1'b1;
      status[ST_INEXACT] = 1'b1;
      if (ovf_to_max) begin
        sum = {s_sign, EXP_ONES - {{(exp_width-1){1'b0}}, 1'b1}, {sig_width{1'b1}}};
      end else begin
        sum = {s_sign, EXP_ONES, {sig_width{1'b0}}};
        status[ST_INF] = 1'b1;
      end
    end else if (e_fin <= ZERO_X) begin
      sum = {s_sign, {(sig_width+exp_width){1'b0}}};
      status[ST_ZERO] = 1'b1;
      status[ST_TINY] = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else begin
      sum = {s_sign, e_fin[exp_width-1:0], frac};
      status[ST_INEXACT] = g_bit | st_bit;
    end
  end

endmodule

// File: rtl/fp_dp_seq.sv
// Streaming floating-point dot-product engine (IDLE/ACC/DONE) with sticky status.
// Define FP_DP_SEQ_BIAS_EN to add a bias port c that seeds the accumulator.
module fp_dp_seq
  import fp_dp_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int max_terms       = 16,
  localparam int LW             = $clog2(max_terms + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LW-1:0]                len,
  input  logic [2:0]                   rnd,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
`ifdef FP_DP_SEQ_BIAS_EN
  input  logic [sig_width+exp_width:0] c,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status,
  output logic                         busy
);
  localparam int FW = sig_width + exp_width + 1;

  function automatic logic [7:0] final_status(input logic [FW-1:0] v, input logic [7:0] stk);
    logic [7:0] s;
    s = stk & STICKY_MASK;
    s[ST_ZERO] = (v[sig_width +: exp_width] == {exp_width{1'b0}});
    s[ST_INF]  = (v[sig_width +: exp_width] == {exp_width{1'b1}});
    return s;
  endfunction

  dp_state_e     state_q, state_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d, len_clamp_s;
  logic [2:0]    rnd_q, rnd_d;
  logic [FW-1:0] acc_q, acc_d, z_q, z_d, init_s, mac_sum_s;
  logic [7:0]    sticky_q, sticky_d, status_q, status_d, mac_status_s;
  logic          last_s;

`ifdef FP_DP_SEQ_BIAS_EN
  assign init_s = c;
`else
  assign init_s = {FW{1'b0}};
`endif

  assign len_clamp_s = (len > LW'(max_terms)) ? LW'(max_terms) : len;
  assign last_s      = (cnt_q == (len_q - LW'(1)));

  fp_dp_mac_step #(
    .sig_width       (sig_width),
    .exp_width       (exp_width),
    .ieee_compliance (ieee_compliance)
  ) u_mac (
    .a      (a),
    .b      (b),
    .acc    (acc_q),
    .rnd    (rnd_q),
    .sum    (mac_sum_s),
    .status (mac_status_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ((len == {LW{1'b0}}) ? DONE : ACC) : IDLE;
      ACC:     state_d = (in_valid && last_s) ? DONE : ACC;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Operand capture on start, per-beat accumulation, and result latch on entry to DONE.
  always_comb begin
    len_d    = len_q;
    rnd_d    = rnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len_clamp_s;
          rnd_d    = rnd;
          acc_d    = init_s;
          sticky_d = 8'h00;
          cnt_d    = {LW{1'b0}};
          if (len == {LW{1'b0}}) begin
            z_d      = init_s;
            status_d = final_status(init_s, 8'h00);
          end else begin
            z_d      = z_q;
          end
        end else begin
          len_d = len_q;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d    = mac_sum_s;
          cnt_d    = cnt_q + LW'(1);
          sticky_d = sticky_q | (mac_status_s & STICKY_MASK);
          if (last_s) begin
            z_d      = mac_sum_s;
            status_d = final_status(mac_sum_s, sticky_d);
          end else begin
            z_d      = z_q;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= {LW{1'b0}};
      rnd_q    <= 3'd0;
      acc_q    <= {FW{1'b0}};
      cnt_q    <= {LW{1'b0}};
      sticky_q <= 8'h00;
      z_q      <= {FW{1'b0}};
      status_q <= 8'h00;
    end else begin
      len_q    <= len_d;
      rnd_q    <= rnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      status_q <= status_d;
    end
  end

  assign z      = z_q;
  assign status = status_q;

endmodule

// File: tb/tb_fp_dp_seq.sv
// Directed self-checking bench for fp_dp_seq (FP32, max_terms = 16).
module tb_fp_dp_seq;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [LW-1:0] len;
  logic [2:0]    rnd;
  logic [31:0]   a, b;
`ifdef FP_DP_SEQ_BIAS_EN
  logic [31:0]   c;
`endif
  logic          in_ready, out_valid, busy;
  logic [31:0]   z;
  logic [7:0]    status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LW-1:0]    len;
    logic [2:0]       rnd;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic             chk_z;
    logic [31:0]      z;
    logic [7:0]       st;
    logic [7:0]       st_mask;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  fp_dp_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .rnd(rnd),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef FP_DP_SEQ_BIAS_EN
    .c(c),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .status(status), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [LW-1:0] l, input logic [2:0] r,
                         input logic [3:0][31:0] va, input logic [3:0][31:0] vb,
                         input logic cz, input logic [31:0] ez, input logic [7:0] es,
                         input logic [7:0] em);
    vecs[i].len = l; vecs[i].rnd = r; vecs[i].a = va; vecs[i].b = vb;
    vecs[i].chk_z = cz; vecs[i].z = ez; vecs[i].st = es; vecs[i].st_mask = em;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    start = 1'b1; len = v.len; rnd = v.rnd;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      chk($sformatf("v%0d in_ready beat %0d", idx, i), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; a = v.a[i]; b = v.b[i];
      tick();
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d out_valid latency", idx), {31'd0, out_valid}, 32'd1);
    if (v.chk_z) chk($sformatf("v%0d z", idx), z, v.z);
    chk($sformatf("v%0d status", idx), {24'd0, status & v.st_mask}, {24'd0, v.st});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("v%0d idle after handshake", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int beats;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; rnd = 3'd0; a = 32'd0; b = 32'd0;
`ifdef FP_DP_SEQ_BIAS_EN
    c = 32'd0;
`endif
    tick(); tick();
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset z", z, 32'd0);
    chk("reset status", {24'd0, status}, 32'd0);
    rst = 1'b0;

    set_vec(0, 5'd3, 3'd0, {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000},
            {32'h0, 32'h40000000, 32'h3F800000, 32'h3F800000}, 1'b1, 32'h41100000, 8'h00, 8'hFF);
    set_vec(1, 5'd0, 3'd0, '0, '0, 1'b1, 32'h00000000, 8'h01, 8'hFF);
    set_vec(2, 5'd1, 3'd0, {96'h0, 32'h40000000}, {96'h0, 32'h40000000}, 1'b1, 32'h40800000, 8'h00, 8'hFF);
    set_vec(3, 5'd2, 3'd0, {64'h0, 32'hBF800000, 32'h3F800000}, {64'h0, 32'h3F800000, 32'h3F800000},
            1'b1, 32'h00000000, 8'h01, 8'hFF);
    set_vec(4, 5'd2, 3'd3, {64'h0, 32'hBF800000, 32'h3F800000}, {64'h0, 32'h3F800000, 32'h3F800000},
            1'b1, 32'h80000000, 8'h01, 8'hFF);
    set_vec(5, 5'd2, 3'd0, {64'h0, 32'h3F800000, 32'h3F800000}, {64'h0, 32'h33800000, 32'h3F800000},
            1'b1, 32'h3F800000, 8'h20, 8'hFF);
    set_vec(6, 5'd2, 3'd2, {64'h0, 32'h3F800000, 32'h3F800000}, {64'h0, 32'h33800000, 32'h3F800000},
            1'b1, 32'h3F800001, 8'h20, 8'hFF);
    set_vec(7, 5'd1, 3'd0, {96'h0, 32'h7F000000}, {96'h0, 32'h40000000}, 1'b1, 32'h7F800000, 8'h32, 8'hFF);
    set_vec(8, 5'd1, 3'd1, {96'h0, 32'h7F000000}, {96'h0, 32'h40000000}, 1'b1, 32'h7F7FFFFF, 8'h30, 8'hFF);
    set_vec(9, 5'd2, 3'd0, {64'h0, 32'h3F800000, 32'h7F800000}, {64'h0, 32'h3F800000, 32'h00000000},
            1'b0, 32'h0, 8'h04, 8'h04);
    set_vec(10, 5'd1, 3'd0, {96'h0, 32'h00800000}, {96'h0, 32'h3F000000}, 1'b1, 32'h00000000, 8'h09, 8'h09);
    set_vec(11, 5'd1, 3'd0, {96'h0, 32'hC0400000}, {96'h0, 32'h40000000}, 1'b1, 32'hC0C00000, 8'h00, 8'hFF);
    set_vec(12, 5'd4, 3'd0, {32'hBF800000, 32'h40400000, 32'h3F800000, 32'h3F800000},
            {32'h40800000, 32'h40000000, 32'h40000000, 32'h40000000}, 1'b1, 32'h40C00000, 8'h00, 8'hFF);

    for (int i = 0; i < 13; i++) run_vec(i);

    // Bubbled input and held-off consumer.
    start = 1'b1; len = 5'd4; rnd = 3'd0;
    tick();
    start = 1'b0; beats = 0; a = 32'h3F800000; b = 32'h3F800000;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc % 2 == 0);
      if (in_valid && in_ready) beats++;
      tick();
    end
    in_valid = 1'b0;
    chk("bubble beats consumed", beats, 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("held out_valid", {31'd0, out_valid}, 32'd1);
      chk("held z", z, 32'h40800000);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid drops after handshake", {31'd0, out_valid}, 32'd0);
    chk("z kept after handshake", z, 32'h40800000);

    // Reset in the middle of a vector.
    start = 1'b1; len = 5'd5;
    tick();
    start = 1'b0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid reset z", z, 32'd0);
    rst = 1'b0;
    run_vec(2);

    // Starts during ACC and during the DONE handshake are ignored.
    start = 1'b1; len = 5'd2; a = 32'h3F800000; b = 32'h3F800000;
    tick();
    len = 5'd0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    chk("start in ACC ignored out_valid", {31'd0, out_valid}, 32'd1);
    chk("start in ACC ignored z", z, 32'h40000000);
    out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("start at handshake ignored", {31'd0, busy}, 32'd0);
    tick();
    chk("still idle", {31'd0, busy}, 32'd0);

    // Length above max_terms is clamped.
    start = 1'b1; len = 5'd31;
    tick();
    start = 1'b0; beats = 0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (in_ready) beats++;
      tick();
    end
    in_valid = 1'b0;
    chk("clamped beats", beats, 32'd16);
    chk("clamped out_valid", {31'd0, out_valid}, 32'd1);
    chk("clamped z", z, 32'h41800000);
    chk("clamped status", {24'd0, status}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef FP_DP_SEQ_BIAS_EN
    c = 32'h3F800000; start = 1'b1; len = 5'd0;
    tick();
    start = 1'b0;
    chk("bias len0 out_valid", {31'd0, out_valid}, 32'd1);
    chk("bias len0 z", z, 32'h3F800000);
    chk("bias len0 status", {24'd0, status}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; c = 32'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
